// File: rtl/fpadd_vector_driver_if.sv
// fpadd_vector_driver_if: start/ROM/adder/status bundle between the vector driver and its surroundings.
interface fpadd_vector_driver_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] vec_addr;
    logic [95:0]       vec_data;
    logic [31:0]       reg_A;
    logic [31:0]       reg_B;
    logic [31:0]       result;
    logic              busy;
    logic              done;
    logic              mismatch;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_idx;
    modport master (
        input  start, vec_data, result,
        output vec_addr, reg_A, reg_B, busy, done, mismatch, err_count, first_err_idx
    );
    modport slave (
        output start, vec_data, result,
        input  vec_addr, reg_A, reg_B, busy, done, mismatch, err_count, first_err_idx
    );
endinterface

// File: rtl/fpadd_vector_driver.sv
// fpadd_vector_driver: walks a ROM of {A, B, expected} vectors through the adder and tallies mismatches.
module fpadd_vector_driver #(
    parameter int NUM_VEC = 11,
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    fpadd_vector_driver_if.master  bus
);
    localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, CHECK, DONE} state_e;
    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] first_err_idx_q;
    logic [WW-1:0]     wcnt_q;
    logic [31:0]       reg_a_q;
    logic [31:0]       reg_b_q;
    logic [31:0]       exp_q;
    logic [CNT_W-1:0]  err_count_q;
    logic [CNT_W-1:0]  err_count_d;
    logic              busy_q;
    logic              done_q;
    logic              mismatch_q;
    assign err_count_d = &err_count_q ? err_count_q : err_count_q + 1'b1;
    // The ROM address is simply the current index; the ROM read lands in LOAD.
    assign bus.vec_addr      = idx_q;
    assign bus.reg_A         = reg_a_q;
    assign bus.reg_B         = reg_b_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.mismatch      = mismatch_q;
    assign bus.err_count     = err_count_q;
    assign bus.first_err_idx = first_err_idx_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            first_err_idx_q <= '0;
            wcnt_q          <= '0;
            reg_a_q         <= '0;
            reg_b_q         <= '0;
            exp_q           <= '0;
            err_count_q     <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            mismatch_q      <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            case (state_q)
                IDLE, DONE: if (bus.start) begin
                    state_q         <= FETCH;
                    idx_q           <= '0;
                    err_count_q     <= '0;
                    first_err_idx_q <= '0;
                    done_q          <= 1'b0;
                    busy_q          <= 1'b1;
                end
                FETCH: state_q <= LOAD;
                LOAD: begin
                    reg_a_q <= bus.vec_data[95:64];
                    reg_b_q <= bus.vec_data[63:32];
                    exp_q   <= bus.vec_data[31:0];
                    wcnt_q  <= WW'(LATENCY - 1);
                    state_q <= WAIT;
                end
                // Result is sampled on the edge entering CHECK, LATENCY cycles after LOAD.
                WAIT: if (wcnt_q == '0) begin
                    state_q <= CHECK;
                    if (bus.result != exp_q) begin
                        mismatch_q  <= 1'b1;
                        err_count_q <= err_count_d;
                        if (err_count_q == '0) first_err_idx_q <= idx_q;
                    end
                end else begin
                    wcnt_q <= wcnt_q - 1'b1;
                end
                CHECK: if (idx_q == ADDR_W'(NUM_VEC - 1)) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= FETCH;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpadd_vector_driver.sv
// tb_fpadd_vector_driver: random vector tables, a stand-in adder with selectable latency, and a table-level model.
module tb_fpadd_vector_driver;
    localparam int N   = 11;
    localparam int L   = 2;
    localparam int RUN = N * (L + 3);
    logic clk = 1'b0;
    logic reset = 1'b1;
    fpadd_vector_driver_if #(.ADDR_W(4), .CNT_W(16)) bus ();
    fpadd_vector_driver #(.NUM_VEC(N), .ADDR_W(4), .LATENCY(L), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    logic [95:0] rom [16];
    logic [31:0] p1, p2;
    int add_lat = 2;
    always @(posedge clk) begin
        bus.vec_data <= rom[bus.vec_addr];
        p1 <= bus.reg_A + bus.reg_B;
        p2 <= p1;
    end
    // add_lat counts cycles from operand change to a result usable at the sampling edge.
    assign bus.result = (add_lat == 3) ? p2 : p1;
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] ta [N];
    logic [31:0] tbv [N];
    logic [31:0] te [N];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask
    task automatic load_table(input logic [15:0] bad);
        for (int i = 0; i < N; i++) begin
            ta[i]  = $urandom;
            tbv[i] = $urandom;
            te[i]  = ta[i] + tbv[i];
            if (bad[i]) te[i] = te[i] ^ (32'h1 << $urandom_range(31, 0));
            rom[i] = {ta[i], tbv[i], te[i]};
        end
    endtask
    task automatic pulse_start;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask
    task automatic check_zero(input string name);
        chk({name, "/vec_addr"}, bus.vec_addr, 0);
        chk({name, "/reg_A"}, bus.reg_A, 0);
        chk({name, "/reg_B"}, bus.reg_B, 0);
        chk({name, "/busy"}, bus.busy, 0);
        chk({name, "/done"}, bus.done, 0);
        chk({name, "/mismatch"}, bus.mismatch, 0);
        chk({name, "/err_count"}, bus.err_count, 0);
        chk({name, "/first_err"}, bus.first_err_idx, 0);
    endtask
    task automatic run_vec(input string name, input bit inject);
        int n, cnt, first, mis_cycles;
        logic [15:0] want_mask, got_mask;
        logic [31:0] s;
        cnt = 0;
        first = -1;
        want_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (add_lat == 2) s = ta[i] + tbv[i];
            else s = (i == 0) ? last_a + last_b : ta[i-1] + tbv[i-1];
            if (s != te[i]) begin
                want_mask[i] = 1'b1;
                cnt++;
                if (first < 0) first = i;
            end
        end
        pulse_start;
        chk({name, "/busy_on"}, bus.busy, 1);
        chk({name, "/done_clr"}, bus.done, 0);
        chk({name, "/err_clr"}, bus.err_count, 0);
        got_mask = '0;
        mis_cycles = 0;
        n = 0;
        while (n < RUN + 20) begin
            @(posedge clk);
            #1 bus.start = 1'b0;
            n++;
            if (bus.mismatch) begin
                mis_cycles++;
                got_mask[bus.vec_addr] = 1'b1;
            end
            if (bus.done) break;
            if (inject && (n % 7 == 3 || n == RUN - 1)) bus.start = 1'b1;
        end
        chk({name, "/cycles"}, n, RUN);
        chk({name, "/busy_off"}, bus.busy, 0);
        chk({name, "/err_count"}, bus.err_count, cnt);
        chk({name, "/mis_mask"}, got_mask, want_mask);
        chk({name, "/mis_cycles"}, mis_cycles, cnt);
        if (cnt > 0) chk({name, "/first_err"}, bus.first_err_idx, first);
        chk({name, "/reg_A"}, bus.reg_A, ta[N-1]);
        chk({name, "/reg_B"}, bus.reg_B, tbv[N-1]);
        @(posedge clk);
        #1 chk({name, "/done_hold"}, bus.done, 1);
        chk({name, "/addr_hold"}, bus.vec_addr, N - 1);
        last_a = ta[N-1];
        last_b = tbv[N-1];
    endtask
    initial begin
        int k;
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = '0;
        repeat (3) @(posedge clk);
        #1 check_zero("rst");
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1 check_zero("idle");
        load_table(16'h0000);
        run_vec("good", 1'b0);
        load_table(16'h0088);
        run_vec("bad37", 1'b0);
        add_lat = 3;
        load_table(16'h0000);
        run_vec("lat3", 1'b0);
        add_lat = 2;
        load_table(16'h0000);
        run_vec("inject", 1'b1);
        load_table(16'h0000);
        pulse_start;
        k = 0;
        while (bus.vec_addr != 4'd5 && k < 100) begin
            @(posedge clk);
            #1 k++;
        end
        chk("midrun/reach5", bus.vec_addr, 5);
        reset = 1'b1;
        #1 check_zero("midrun_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        last_a = '0;
        last_b = '0;
        repeat (5) @(posedge clk);
        #1 check_zero("post_rst");
        load_table(16'h0001);
        run_vec("after_rst", 1'b0);
        load_table(16'h0400);
        run_vec("b2b_1", 1'b0);
        load_table(16'h0000);
        run_vec("b2b_2", 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
